vga_timing: RTL and testbench

VGA_TIMING -- requirements
Module: vga_timing

---
 rtl/vga_timing_pkg.sv | 29 ++
 rtl/vga_timing.sv | 114 +++++++++++
 tb/tb_vga_timing.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// Shared types and default 640x480@60 timing constants for the VGA timing generator.
package vga_timing_pkg;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } color_t;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;
    localparam int CLK_DIV_DEF  = 2;

    // Eight vertical colour bars: bit 2 drives red, bit 1 green, bit 0 blue.
    function automatic color_t bar_color(input logic [2:0] idx);
        color_t c;
        c.r = idx[2] ? 4'hF : 4'h0;
        c.g = idx[1] ? 4'hF : 4'h0;
        c.b = idx[0] ? 4'hF : 4'h0;
        return c;
    endfunction

endpackage

// File: rtl/vga_timing.sv
// VGA raster timing generator with a one-pixel-period registered pin stage.
// Optional colour-bar test pattern enabled by defining VGA_TEST_PATTERN_EN (adds port test_en).
module vga_timing
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter int CLK_DIV  = CLK_DIV_DEF
) (
    input  logic       clk,
    input  logic       rst,
`ifdef VGA_TEST_PATTERN_EN
    input  logic       test_en,
`endif
    input  color_t     pixel_color,
    output logic       pix_en,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       active,
    output logic       frame_start,
    output color_t     vga_color,
    output logic       vga_hs,
    output logic       vga_vs
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_W     = $clog2(H_TOTAL);
    localparam int V_W     = $clog2(V_TOTAL);
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [H_W-1:0]   H_LAST   = H_W'(H_TOTAL - 1);
    localparam logic [V_W-1:0]   V_LAST   = V_W'(V_TOTAL - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [H_W-1:0]   hcnt_q, hcnt_d;
    logic [V_W-1:0]   vcnt_q, vcnt_d;
    color_t           color_q, color_d;
    logic             hs_q, hs_d;
    logic             vs_q, vs_d;

    logic   hsync_raw;
    logic   vsync_raw;
    color_t active_color;

    // Reset gating keeps pix_en low during reset even when CLK_DIV=1.
    assign pix_en      = !rst && (div_q == DIV_LAST);
    assign active      = (int'(hcnt_q) < H_ACTIVE) && (int'(vcnt_q) < V_ACTIVE);
    assign x           = active ? 10'(hcnt_q) : 10'd0;
    assign y           = active ? 10'(vcnt_q) : 10'd0;
    assign frame_start = pix_en && (hcnt_q == '0) && (vcnt_q == '0);

    assign hsync_raw = !((int'(hcnt_q) >= H_ACTIVE + H_FP) &&
                         (int'(hcnt_q) <  H_ACTIVE + H_FP + H_SYNC));
    assign vsync_raw = !((int'(vcnt_q) >= V_ACTIVE + V_FP) &&
                         (int'(vcnt_q) <  V_ACTIVE + V_FP + V_SYNC));

`ifdef VGA_TEST_PATTERN_EN
    assign active_color = test_en ? bar_color(3'(x / 10'd80)) : pixel_color;
`else
    assign active_color = pixel_color;
`endif

    always_comb begin
        div_d   = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
        hcnt_d  = hcnt_q;
        vcnt_d  = vcnt_q;
        color_d = color_q;
        hs_d    = hs_q;
        vs_d    = vs_q;
        if (pix_en) begin
            // Pins capture the current pixel, so they trail x/y by one pixel period.
            color_d = active ? active_color : '0;
            hs_d    = hsync_raw;
            vs_d    = vsync_raw;
            if (hcnt_q == H_LAST) begin
                hcnt_d = '0;
                vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + V_W'(1);
            end else begin
                hcnt_d = hcnt_q + H_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q   <= '0;
            hcnt_q  <= '0;
            vcnt_q  <= '0;
            color_q <= '0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
        end else begin
            div_q   <= div_d;
            hcnt_q  <= hcnt_d;
            vcnt_q  <= vcnt_d;
            color_q <= color_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
        end
    end

    assign vga_color = color_q;
    assign vga_hs    = hs_q;
    assign vga_vs    = vs_q;

endmodule

// File: tb/tb_vga_timing.sv
// Self-checking bench: default-timing line checks, CLK_DIV=1 checks, and a scoreboard on a tiny raster.
module tb_vga_timing;
    import vga_timing_pkg::*;

    // Tiny raster for dut_b: H 16+2+3+3=24, V 6+1+2+1=10, 3 clk per pixel.
    localparam int B_HA = 16, B_HF = 2, B_HS = 3, B_HB = 3;
    localparam int B_VA = 6,  B_VF = 1, B_VS = 2, B_VB = 1;
    localparam int B_DIV = 3;
    localparam int B_HT = B_HA + B_HF + B_HS + B_HB;
    localparam int B_VT = B_VA + B_VF + B_VS + B_VB;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;
    color_t col_a = 12'hFFF, col_b = 12'h000, col_c = 12'h5A3;

    logic       pe_a, pe_b, pe_c, act_a, act_b, act_c, fs_a, fs_b, fs_c;
    logic [9:0] x_a, x_b, x_c, y_a, y_b, y_c;
    color_t     vc_a, vc_b, vc_c;
    logic       hs_a, hs_b, hs_c, vs_a, vs_b, vs_c;
`ifdef VGA_TEST_PATTERN_EN
    logic ten_a = 1'b0, ten_b = 1'b0, ten_c = 1'b0;
`endif

    vga_timing dut_a (
        .clk(clk), .rst(rst_a),
`ifdef VGA_TEST_PATTERN_EN
        .test_en(ten_a),
`endif
        .pixel_color(col_a), .pix_en(pe_a), .x(x_a), .y(y_a), .active(act_a),
        .frame_start(fs_a), .vga_color(vc_a), .vga_hs(hs_a), .vga_vs(vs_a)
    );

    vga_timing #(
        .H_ACTIVE(B_HA), .H_FP(B_HF), .H_SYNC(B_HS), .H_BP(B_HB),
        .V_ACTIVE(B_VA), .V_FP(B_VF), .V_SYNC(B_VS), .V_BP(B_VB), .CLK_DIV(B_DIV)
    ) dut_b (
        .clk(clk), .rst(rst_b),
`ifdef VGA_TEST_PATTERN_EN
        .test_en(ten_b),
`endif
        .pixel_color(col_b), .pix_en(pe_b), .x(x_b), .y(y_b), .active(act_b),
        .frame_start(fs_b), .vga_color(vc_b), .vga_hs(hs_b), .vga_vs(vs_b)
    );

    vga_timing #(.CLK_DIV(1)) dut_c (
        .clk(clk), .rst(rst_c),
`ifdef VGA_TEST_PATTERN_EN
        .test_en(ten_c),
`endif
        .pixel_color(col_c), .pix_en(pe_c), .x(x_c), .y(y_c), .active(act_c),
        .frame_start(fs_c), .vga_color(vc_c), .vga_hs(hs_c), .vga_vs(vs_c)
    );

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        color_t col;
        logic   hs;
        logic   vs;
    } pins_t;

    pins_t exp_q[$];
    pins_t cur_pins;
    int    mdiv, mh, mv;

    task automatic test_reset();
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        tests++;
        if ({pe_a, fs_a, vc_a, hs_a, vs_a, x_a, y_a} !== {1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 10'd0, 10'd0}) begin
            fails++;
            $display("FAIL reset_a: got pe=%b fs=%b col=%h hs=%b vs=%b x=%0d y=%0d expected 0 0 000 1 1 0 0",
                     pe_a, fs_a, vc_a, hs_a, vs_a, x_a, y_a);
        end
        tests++;
        if ({pe_b, fs_b, vc_b, hs_b, vs_b} !== {1'b0, 1'b0, 12'h000, 1'b1, 1'b1}) begin
            fails++;
            $display("FAIL reset_b: got pe=%b fs=%b col=%h hs=%b vs=%b expected 0 0 000 1 1",
                     pe_b, fs_b, vc_b, hs_b, vs_b);
        end
        tests++;
        if ({pe_c, fs_c, vc_c, hs_c, vs_c} !== {1'b0, 1'b0, 12'h000, 1'b1, 1'b1}) begin
            fails++;
            $display("FAIL reset_c_div1: got pe=%b fs=%b col=%h hs=%b vs=%b expected 0 0 000 1 1",
                     pe_c, fs_c, vc_c, hs_c, vs_c);
        end
        $display("[TB] reset: all three instances checked while held in reset");
    endtask

    task automatic test_hsync_default();
        int falls[2];
        int nfall = 0, low_cnt = 0, lit = 0, odd = 0, vs_low = 0, first_pe = -1;
        logic prev_hs = 1'b1;
        logic fs_at_first = 1'b0;
        col_a = 12'hFFF;
        @(negedge clk);
        rst_a = 1'b0;
        for (int n = 1; n <= 3400; n++) begin
            @(negedge clk);
            #1;
            if (pe_a && first_pe < 0) begin
                first_pe = n;
                fs_at_first = fs_a;
            end
            if (prev_hs && !hs_a && nfall < 2) begin
                falls[nfall] = n;
                nfall++;
            end
            if (nfall == 1) begin
                if (!hs_a) low_cnt++;
                if (pe_a && vc_a == 12'hFFF) lit++;
                if (vc_a != 12'hFFF && vc_a != 12'h000) odd++;
            end
            if (!vs_a) vs_low++;
            prev_hs = hs_a;
        end
        tests++;
        if (first_pe != 1 || fs_at_first !== 1'b1) begin
            fails++;
            $display("FAIL first_pix_en: got sample %0d fs=%b expected sample 1 fs=1", first_pe, fs_at_first);
        end
        tests++;
        if (nfall != 2) begin
            fails++;
            $display("FAIL hs_falls: got %0d falls expected 2", nfall);
        end else begin
            tests++;
            if (falls[0] != 1314) begin
                fails++;
                $display("FAIL hs_first_fall: got %0d clk expected 1314", falls[0]);
            end
            tests++;
            if (falls[1] - falls[0] != 1600) begin
                fails++;
                $display("FAIL hs_period: got %0d clk expected 1600", falls[1] - falls[0]);
            end
        end
        tests++;
        if (low_cnt != 192) begin
            fails++;
            $display("FAIL hs_low_width: got %0d clk expected 192", low_cnt);
        end
        tests++;
        if (lit != 640 || odd != 0) begin
            fails++;
            $display("FAIL lit_pixels: got %0d lit, %0d odd expected 640 lit, 0 odd", lit, odd);
        end
        tests++;
        if (vs_low != 0) begin
            fails++;
            $display("FAIL vs_early: got %0d low clk expected 0", vs_low);
        end
        $display("[TB] hsync_default: first fall %0d, lit %0d, low %0d", falls[0], lit, low_cnt);
    endtask

    task automatic test_clkdiv1();
        int falls[2];
        int nfall = 0, low_cnt = 0, pe_low = 0;
        logic prev_hs = 1'b1;
        @(negedge clk);
        rst_c = 1'b0;
        for (int n = 1; n <= 2000; n++) begin
            @(negedge clk);
            #1;
            if (!pe_c) pe_low++;
            if (prev_hs && !hs_c && nfall < 2) begin
                falls[nfall] = n;
                nfall++;
            end
            if (nfall == 1 && !hs_c) low_cnt++;
            prev_hs = hs_c;
        end
        tests++;
        if (pe_low != 0) begin
            fails++;
            $display("FAIL div1_pix_en: got %0d low samples expected 0", pe_low);
        end
        tests++;
        if (nfall != 2) begin
            fails++;
            $display("FAIL div1_falls: got %0d expected 2", nfall);
        end else begin
            tests++;
            if (falls[0] != 657 || falls[1] - falls[0] != 800) begin
                fails++;
                $display("FAIL div1_line: got first %0d period %0d expected 657 800",
                         falls[0], falls[1] - falls[0]);
            end
        end
        tests++;
        if (low_cnt != 96) begin
            fails++;
            $display("FAIL div1_hs_width: got %0d expected 96", low_cnt);
        end
        $display("[TB] clkdiv1: pix_en low %0d, hs low %0d", pe_low, low_cnt);
    endtask

    task automatic model_init_b();
        mdiv = 0; mh = 0; mv = 0;
        exp_q.delete();
        cur_pins = '{col: 12'h000, hs: 1'b1, vs: 1'b1};
    endtask

    task automatic reset_b();
        @(negedge clk);
        rst_b = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        rst_b = 1'b0;
        #1;
        model_init_b();
    endtask

    // One clk of the scoreboard: pop pins due from the last strobe, check, then predict.
    task automatic step_b();
        logic       exp_pe, act;
        logic [9:0] ex, ey;
        if (exp_q.size() > 0) cur_pins = exp_q.pop_front();
        tests++;
        if ({vc_b, hs_b, vs_b} !== {cur_pins.col, cur_pins.hs, cur_pins.vs}) begin
            fails++;
            $display("FAIL pins_b (%0d,%0d): got col=%h hs=%b vs=%b expected col=%h hs=%b vs=%b",
                     mh, mv, vc_b, hs_b, vs_b, cur_pins.col, cur_pins.hs, cur_pins.vs);
        end
        exp_pe = (mdiv == B_DIV - 1);
        act    = (mh < B_HA) && (mv < B_VA);
        ex     = act ? 10'(mh) : 10'd0;
        ey     = act ? 10'(mv) : 10'd0;
        tests++;
        if ({pe_b, x_b, y_b, act_b, fs_b} !== {exp_pe, ex, ey, act, exp_pe && mh == 0 && mv == 0}) begin
            fails++;
            $display("FAIL raster_b: got pe=%b x=%0d y=%0d act=%b fs=%b expected pe=%b x=%0d y=%0d act=%b fs=%b",
                     pe_b, x_b, y_b, act_b, fs_b, exp_pe, ex, ey, act, exp_pe && mh == 0 && mv == 0);
        end
        if (exp_pe) begin
            col_b = color_t'($urandom_range(0, 4095));
            exp_q.push_back('{col: act ? col_b : 12'h000,
                              hs: !(mh >= B_HA + B_HF && mh < B_HA + B_HF + B_HS),
                              vs: !(mv >= B_VA + B_VF && mv < B_VA + B_VF + B_VS)});
            mdiv = 0;
            if (mh == B_HT - 1) begin
                mh = 0;
                mv = (mv == B_VT - 1) ? 0 : mv + 1;
            end else begin
                mh++;
            end
        end else begin
            mdiv++;
        end
        @(negedge clk);
        #1;
    endtask

    task automatic test_scoreboard();
        int t0 = tests, f0 = fails;
        reset_b();
        repeat (2 * B_HT * B_VT * B_DIV + 50) step_b();
        $display("[TB] scoreboard: %0d checks over two small frames, %0d bad", tests - t0, fails - f0);
    endtask

    task automatic test_reset_mid();
        bit found = 0;
        reset_b();
        for (int i = 0; i < 2 * B_HT * B_VT * B_DIV; i++) begin
            step_b();
            if (mh == B_HA + B_HF + 1 && mv == B_VA + B_VF && mdiv == B_DIV - 1) begin
                found = 1;
                break;
            end
        end
        tests++;
        if (!found) begin
            fails++;
            $display("FAIL mid_reset_reach: got no sync-region point expected one within bound");
        end else begin
            tests++;
            if ({hs_b, vs_b, pe_b} !== 3'b001) begin
                fails++;
                $display("FAIL mid_reset_pre: got hs=%b vs=%b pe=%b expected 0 0 1", hs_b, vs_b, pe_b);
            end
            rst_b = 1'b1;
            @(negedge clk);
            #1;
            tests++;
            if ({hs_b, vs_b, vc_b, pe_b, act_b, x_b, y_b} !== {1'b1, 1'b1, 12'h000, 1'b0, 1'b1, 10'd0, 10'd0}) begin
                fails++;
                $display("FAIL mid_reset: got hs=%b vs=%b col=%h pe=%b act=%b x=%0d y=%0d expected 1 1 000 0 1 0 0",
                         hs_b, vs_b, vc_b, pe_b, act_b, x_b, y_b);
            end
            rst_b = 1'b0;
            #1;
            model_init_b();
            repeat (3 * B_HT * B_DIV) step_b();
        end
        $display("[TB] reset_mid: pulse applied in sync region, restart followed");
    endtask

`ifdef VGA_TEST_PATTERN_EN
    task automatic test_pattern();
        int targets[2];
        color_t want[2];
        targets[0] = 85;  want[0] = 12'h00F;
        targets[1] = 639; want[1] = 12'hFFF;
        ten_a = 1'b1;
        col_a = 12'h123;
        @(negedge clk);
        rst_a = 1'b1;
        repeat (2) @(negedge clk);
        rst_a = 1'b0;
        for (int k = 0; k < 2; k++) begin
            bit hit = 0;
            for (int n = 0; n < 4000; n++) begin
                @(negedge clk);
                #1;
                if (pe_a && act_a && x_a == 10'(targets[k])) begin
                    hit = 1;
                    break;
                end
            end
            @(negedge clk);
            #1;
            tests++;
            if (!hit || vc_a !== want[k]) begin
                fails++;
                $display("FAIL bar_x%0d: got hit=%0d col=%h expected hit=1 col=%h", targets[k], hit, vc_a, want[k]);
            end
        end
        ten_a = 1'b0;
        $display("[TB] test_pattern: bars at x=85 and x=639 checked");
    endtask
`endif

    initial begin
        test_reset();
        test_hsync_default();
        test_clkdiv1();
        test_scoreboard();
        test_reset_mid();
`ifdef VGA_TEST_PATTERN_EN
        test_pattern();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
